// File: rtl/mem_controller.sv
// mem_controller: arbitrates instruction fetch and load/store traffic onto an
// 8-bit little-endian RAM/IO bus, one byte per cycle, one transaction at a time.
module mem_controller #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_clear,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_store,
  input  logic [5:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_mem_valid,
  output logic [31:0] lsb_mem_val,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_d;
  logic [1:0]  cnt, cnt_d, last, last_d;
  logic        fetch_q, fetch_d, abort_q, abort_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] wdata_q, wdata_d, rbuf, rbuf_d, addr_q, addr_d;
  logic [7:0]  dout_q, dout_d, next_byte;
  logic        wr_q, wr_d;
  logic        if_valid_q, if_valid_d, lsb_valid_q, lsb_valid_d;
  logic [31:0] if_data_q, if_data_d, lsb_val_q, lsb_val_d;
  logic [31:0] word_now, load_val;
  logic [1:0]  lsb_last;
  logic        io_hit, io_block;

  assign mem_a         = addr_q;
  assign mem_dout      = dout_q;
  assign mem_wr        = wr_q & rdy_in;
  assign if_valid      = if_valid_q;
  assign if_data       = if_data_q;
  assign lsb_mem_valid = lsb_valid_q;
  assign lsb_mem_val   = lsb_val_q;

  assign io_hit   = (lsb_addr == IO_BASE) || (lsb_addr == IO_BASE + 32'd4);
  assign io_block = lsb_store && io_hit && io_buffer_full;

  always_comb begin
    case (lsb_op)
      OP_LB, OP_LBU, OP_SB: lsb_last = 2'd0;
      OP_LH, OP_LHU, OP_SH: lsb_last = 2'd1;
      default:              lsb_last = 2'd3;
    endcase
  end

  // Word as it stands once this edge's byte is captured into lane cnt.
  always_comb begin
    word_now = rbuf;
    case (cnt)
      2'd0:    word_now[7:0]   = mem_din;
      2'd1:    word_now[15:8]  = mem_din;
      2'd2:    word_now[23:16] = mem_din;
      default: word_now[31:24] = mem_din;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_LB:   load_val = {{24{word_now[7]}}, word_now[7:0]};
      OP_LH:   load_val = {{16{word_now[15]}}, word_now[15:0]};
      OP_LBU:  load_val = {24'd0, word_now[7:0]};
      OP_LHU:  load_val = {16'd0, word_now[15:0]};
      default: load_val = word_now;
    endcase
  end

  always_comb begin
    case (cnt)
      2'd0:    next_byte = wdata_q[15:8];
      2'd1:    next_byte = wdata_q[23:16];
      default: next_byte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    last_d      = last;
    fetch_d     = fetch_q;
    abort_d     = abort_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf;
    addr_d      = addr_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    if_valid_d  = 1'b0;
    lsb_valid_d = 1'b0;
    if_data_d   = if_data_q;
    lsb_val_d   = lsb_val_q;
    case (state)
      IDLE: begin
        if (!mem_clear) begin
          if (lsb_req) begin
            if (!io_block) begin
              fetch_d = 1'b0;
              abort_d = 1'b0;
              op_d    = lsb_op;
              last_d  = lsb_last;
              addr_d  = lsb_addr;
              cnt_d   = 2'd0;
              rbuf_d  = '0;
              if (lsb_store) begin
                wdata_d = lsb_wdata;
                dout_d  = lsb_wdata[7:0];
                wr_d    = 1'b1;
                state_d = WRITE;
              end else begin
                state_d = READ;
              end
            end
          end else if (if_req) begin
            fetch_d = 1'b1;
            abort_d = 1'b0;
            op_d    = OP_LW;
            last_d  = 2'd3;
            addr_d  = if_addr;
            cnt_d   = 2'd0;
            rbuf_d  = '0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (mem_clear) begin
          wr_d    = 1'b0;
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          rbuf_d = word_now;
          if (cnt == last) begin
            state_d = DONE;
            if (fetch_q) begin
              if_valid_d = 1'b1;
              if_data_d  = word_now;
            end else begin
              lsb_valid_d = 1'b1;
              lsb_val_d   = load_val;
            end
          end else begin
            cnt_d  = cnt + 2'd1;
            addr_d = addr_q + 32'd1;
          end
        end
      end
      WRITE: begin
        // A flush cannot retract bytes already on the bus; finish, but stay silent.
        if (mem_clear) abort_d = 1'b1;
        if (cnt == last) begin
          wr_d        = 1'b0;
          cnt_d       = 2'd0;
          state_d     = DONE;
          lsb_valid_d = !(abort_q || mem_clear);
        end else begin
          cnt_d  = cnt + 2'd1;
          addr_d = addr_q + 32'd1;
          dout_d = next_byte;
        end
      end
      default: begin
        cnt_d   = 2'd0;
        abort_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= '0;
      fetch_q     <= 1'b0;
      abort_q     <= 1'b0;
      op_q        <= '0;
      wdata_q     <= '0;
      rbuf        <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      if_valid_q  <= 1'b0;
      lsb_valid_q <= 1'b0;
      if_data_q   <= '0;
      lsb_val_q   <= '0;
    end else if (rdy_in) begin
      state       <= state_d;
      cnt         <= cnt_d;
      last        <= last_d;
      fetch_q     <= fetch_d;
      abort_q     <= abort_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      rbuf        <= rbuf_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      if_valid_q  <= if_valid_d;
      lsb_valid_q <= lsb_valid_d;
      if_data_q   <= if_data_d;
      lsb_val_q   <= lsb_val_d;
    end
  end

endmodule
